// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS lane decoder.
//   SYM_W       - TMDS symbol width in bits
//   TOKEN_Cxx   - the four DVI control tokens, written q9..q0
//   dec_state_t - alignment state of a lane decoder
package tmds_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } dec_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol.
// Ports:
//   symbol - aligned symbol, q9..q0
//   data   - decoded pixel byte (0 for control tokens)
//   c      - control bits {c1,c0} when symbol is a token, else 0
//   de     - 1 for a data symbol, 0 for a control token
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] symbol,
    output logic [7:0]       data,
    output logic [1:0]       c,
    output logic             de
);

    logic [7:0] d;

    always_comb begin
        // q9 marks the byte as transmitted inverted
        d    = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        data = '0;
        c    = '0;
        de   = 1'b0;
        case (symbol)
            TOKEN_C00: c = 2'b00;
            TOKEN_C01: c = 2'b01;
            TOKEN_C10: c = 2'b10;
            TOKEN_C11: c = 2'b11;
            default: begin
                de      = 1'b1;
                data[0] = d[0];
                // q8 selects XOR (1) or XNOR (0) chaining
                for (int i = 1; i < 8; i++) begin
                    data[i] = symbol[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One DVI TMDS lane: finds the symbol boundary by bit-slipping until a run of
// control tokens is seen at one offset, then decodes pixel data / control.
// Optional slip statistics are built when TMDS_CHANNEL_DECODER_STATS_EN is
// defined; otherwise out_stats is 0 and stats_clear is ignored.
// Ports:
//   clk_pixel   - pixel clock
//   reset       - synchronous, active-high
//   in_symbol   - raw deserialized bits, bit 0 earliest on the wire
//   stats_clear - zero out_stats
//   out_data    - decoded pixel byte
//   out_c       - control bits {c1,c0}, held during data
//   out_de      - 1 = data symbol, 0 = control token
//   out_locked  - alignment locked
//   out_offset  - current bit offset 0..9
//   out_stats   - slip / lock-loss event count
//
// state  | meaning
// SEARCH | counting consecutive tokens at out_offset; slip when window expires
// LOCKED | decoding; slip and fall back to SEARCH after too long without tokens
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int C_lock_tokens   = 8,
    parameter int C_search_cycles = 4096,
    parameter int C_timeout       = 4096
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic [SYM_W-1:0] in_symbol,
    input  logic             stats_clear,
    output logic [7:0]       out_data,
    output logic [1:0]       out_c,
    output logic             out_de,
    output logic             out_locked,
    output logic [3:0]       out_offset,
    output logic [15:0]      out_stats
);

    localparam int TOK_W = (C_lock_tokens   > 1) ? $clog2(C_lock_tokens)   : 1;
    localparam int WIN_W = (C_search_cycles > 1) ? $clog2(C_search_cycles) : 1;
    localparam int TO_W  = (C_timeout       > 1) ? $clog2(C_timeout)       : 1;

    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(C_lock_tokens - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_search_cycles - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(C_timeout - 1);

    dec_state_t         state;
    logic [2*SYM_W-1:0] hist;
    logic [TOK_W-1:0]   tok_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic [SYM_W-1:0]   window;
    logic [7:0]         dec_data;
    logic [1:0]         dec_c;
    logic               dec_de;
    logic               is_token;
    logic               lock_hit;
    logic               search_slip;
    logic               timeout;
    logic               slip_evt;
    logic [3:0]         next_offset;

    // Oldest word sits in the low half, so a larger offset looks later in time.
    assign window = SYM_W'(hist >> out_offset);

    tmds_symbol_decode u_decode (
        .symbol (window),
        .data   (dec_data),
        .c      (dec_c),
        .de     (dec_de)
    );

    assign is_token    = ~dec_de;
    assign next_offset = (out_offset == 4'd9) ? 4'd0 : out_offset + 4'd1;
    // Lock takes priority over a slip landing on the same cycle.
    assign lock_hit    = (state == SEARCH) && is_token && (tok_cnt == TOK_LAST);
    assign search_slip = (state == SEARCH) && !lock_hit && (win_cnt == WIN_LAST);
    assign timeout     = (state == LOCKED) && !is_token && (to_cnt == TO_LAST);
    assign slip_evt    = search_slip | timeout;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= SEARCH;
            hist       <= '0;
            tok_cnt    <= '0;
            win_cnt    <= '0;
            to_cnt     <= '0;
            out_offset <= '0;
            out_locked <= 1'b0;
            out_data   <= '0;
            out_c      <= '0;
            out_de     <= 1'b0;
        end else begin
            hist <= {in_symbol, hist[2*SYM_W-1:SYM_W]};
            case (state)
                SEARCH: begin
                    out_data <= '0;
                    out_c    <= '0;
                    out_de   <= 1'b0;
                    if (lock_hit) begin
                        state      <= LOCKED;
                        out_locked <= 1'b1;
                        tok_cnt    <= '0;
                        win_cnt    <= '0;
                        to_cnt     <= '0;
                        out_c      <= dec_c;
                    end else if (search_slip) begin
                        out_offset <= next_offset;
                        tok_cnt    <= '0;
                        win_cnt    <= '0;
                    end else begin
                        tok_cnt <= is_token ? tok_cnt + 1'b1 : '0;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (timeout) begin
                        state      <= SEARCH;
                        out_locked <= 1'b0;
                        out_offset <= next_offset;
                        tok_cnt    <= '0;
                        win_cnt    <= '0;
                        to_cnt     <= '0;
                        out_data   <= '0;
                        out_c      <= '0;
                        out_de     <= 1'b0;
                    end else begin
                        to_cnt   <= is_token ? '0 : to_cnt + 1'b1;
                        out_data <= dec_data;
                        out_de   <= dec_de;
                        if (is_token) begin
                            out_c <= dec_c;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef TMDS_CHANNEL_DECODER_STATS_EN
    logic [15:0] stats;

    always_ff @(posedge clk_pixel) begin
        if (reset || stats_clear) begin
            stats <= '0;
        end else if (slip_evt && (stats != 16'hFFFF)) begin
            stats <= stats + 16'd1;
        end
    end

    assign out_stats = stats;
`else
    logic stats_unused;

    assign stats_unused = stats_clear ^ slip_evt;
    assign out_stats    = '0;
`endif

endmodule
